// File: rtl/dm_access_ctrl_if.sv
// dm_access_ctrl_if
// Bundles the pipeline-side request/response handshake and the data-memory
// port of the MEM-stage load/store controller.
//   slave  modport : seen by dm_access_ctrl (takes requests, drives memory)
//   master modport : seen by the pipeline/memory side (issues requests,
//                    returns dm_dout)
// Signals:
//   req_valid/req_ready/req_we/req_mode/req_signed/req_addr/req_wdata : request
//   resp_valid/resp_rdata/resp_err                                     : response
//   stall                                                              : hazard unit
//   dm_addr/dm_din/dm_we/dm_mode/dm_dout                               : memory port

`ifndef MEM_op_byte
`define MEM_op_byte 2'b01
`endif
`ifndef MEM_op_half
`define MEM_op_half 2'b10
`endif

interface dm_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_mode;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;
    logic [11:0] dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [1:0]  dm_mode;
    logic [31:0] dm_dout;

    modport slave (
        input  req_valid, req_we, req_mode, req_signed, req_addr, req_wdata, dm_dout,
        output req_ready, resp_valid, resp_rdata, resp_err, stall,
               dm_addr, dm_din, dm_we, dm_mode
    );

    modport master (
        output req_valid, req_we, req_mode, req_signed, req_addr, req_wdata, dm_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall,
               dm_addr, dm_din, dm_we, dm_mode
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl
// MEM-stage load/store initiator. Accepts one request at a time, checks
// alignment, drives the data-memory port for WAIT cycles, extends load data
// and returns a one-cycle response. stall is high whenever a request is in
// flight.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : dm_access_ctrl_if.slave (request, response, stall, memory port)
// Parameter:
//   WAIT : ACCESS cycles per memory operation, 1..15

module dm_access_ctrl #(
    parameter int unsigned WAIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    dm_access_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT - 32'd1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic        we_r;
    logic [1:0]  mode_r;
    logic        signed_r;
    logic [11:0] addr_r;
    logic [31:0] wdata_r;
    logic        err_r;
    logic [31:0] rdata_r;

    logic        ready_s;
    logic        accept_s;
    logic        misalign_s;
    logic        last_s;
    logic        unused_addr_hi_s;

    // Byte never misaligned; half needs addr[0]=0; everything else is a word.
    function automatic logic misaligned_f(input logic [1:0] mode, input logic [1:0] a);
        logic res;
        case (mode)
            `MEM_op_byte: res = 1'b0;
            `MEM_op_half: res = a[0];
            default:      res = (a != 2'b00);
        endcase
        return res;
    endfunction

    // Sign/zero extension of load data according to size and signedness.
    function automatic logic [31:0] extend_f(input logic [1:0] mode, input logic sgn,
                                             input logic [31:0] dout);
        logic [31:0] res;
        case (mode)
            `MEM_op_byte: res = {{24{sgn & dout[7]}}, dout[7:0]};
            `MEM_op_half: res = {{16{sgn & dout[15]}}, dout[15:0]};
            default:      res = dout;
        endcase
        return res;
    endfunction

    assign ready_s          = (state_r != ST_ACCESS);
    assign accept_s         = bus.req_valid & ready_s;
    assign misalign_s       = misaligned_f(bus.req_mode, bus.req_addr[1:0]);
    assign last_s           = (state_r == ST_ACCESS) && (cnt_r == 4'd0);
    // Upper address bits wrap silently into the 4 KB window.
    assign unused_addr_hi_s = ^bus.req_addr[31:12];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; RESP may accept the next request back-to-back.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_RESP: begin
                if (accept_s) begin
                    state_nxt_s = misalign_s ? ST_RESP : ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Request latch, wait counter and response data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= 4'd0;
            we_r     <= 1'b0;
            mode_r   <= 2'b00;
            signed_r <= 1'b0;
            addr_r   <= 12'h000;
            wdata_r  <= 32'h0000_0000;
            err_r    <= 1'b0;
            rdata_r  <= 32'h0000_0000;
        end else if (accept_s) begin
            we_r     <= bus.req_we;
            mode_r   <= bus.req_mode;
            signed_r <= bus.req_signed;
            addr_r   <= bus.req_addr[11:0];
            wdata_r  <= bus.req_wdata;
            err_r    <= misalign_s;
            rdata_r  <= 32'h0000_0000;
            cnt_r    <= misalign_s ? 4'd0 : WAIT_LOAD;
        end else if (state_r == ST_ACCESS) begin
            if (cnt_r == 4'd0) begin
                // Stores report zero data; loads capture on the last cycle.
                rdata_r <= we_r ? 32'h0000_0000 : extend_f(mode_r, signed_r, bus.dm_dout);
            end else begin
                cnt_r <= cnt_r - 4'd1;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.req_ready  = ready_s;
    assign bus.stall      = (state_r != ST_IDLE);
    assign bus.resp_valid = (state_r == ST_RESP);
    assign bus.resp_err   = err_r;
    assign bus.resp_rdata = rdata_r;
    assign bus.dm_addr    = addr_r;
    assign bus.dm_din     = wdata_r;
    assign bus.dm_mode    = mode_r;
    // Exactly one write strobe per aligned store, on its last ACCESS cycle.
    assign bus.dm_we      = last_s & we_r;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl
// Directed bench: instance A with WAIT=1 and instance B with WAIT=3, each
// backed by a small byte-addressed memory. Expected values are hand-computed.

`ifndef MEM_op_byte
`define MEM_op_byte 2'b01
`endif
`ifndef MEM_op_half
`define MEM_op_half 2'b10
`endif

module tb_dm_access_ctrl;

    localparam logic [1:0] M_BYTE = `MEM_op_byte;
    localparam logic [1:0] M_HALF = `MEM_op_half;
    localparam logic [1:0] M_WORD = 2'b00;

    logic clk;
    logic rst;
    logic init_mem;
    int   n_cmp;
    int   n_fail;
    int   wr_cnt_a;
    int   wr_cnt_b;
    int   resp_cnt_b;

    logic [7:0] mem_a [0:4095];
    logic [7:0] mem_b [0:4095];

    dm_access_ctrl_if ifa ();
    dm_access_ctrl_if ifb ();

    dm_access_ctrl #(.WAIT(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    dm_access_ctrl #(.WAIT(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory A read port: zero-extended, lane picked from the address.
    always_comb begin
        ifa.dm_dout = 32'h0;
        case (ifa.dm_mode)
            `MEM_op_byte: ifa.dm_dout = {24'h0, mem_a[ifa.dm_addr]};
            `MEM_op_half: ifa.dm_dout = {16'h0, mem_a[{ifa.dm_addr[11:1], 1'b1}],
                                               mem_a[{ifa.dm_addr[11:1], 1'b0}]};
            default:      ifa.dm_dout = {mem_a[{ifa.dm_addr[11:2], 2'b11}], mem_a[{ifa.dm_addr[11:2], 2'b10}],
                                         mem_a[{ifa.dm_addr[11:2], 2'b01}], mem_a[{ifa.dm_addr[11:2], 2'b00}]};
        endcase
    end

    // Memory B read port.
    always_comb begin
        ifb.dm_dout = 32'h0;
        case (ifb.dm_mode)
            `MEM_op_byte: ifb.dm_dout = {24'h0, mem_b[ifb.dm_addr]};
            `MEM_op_half: ifb.dm_dout = {16'h0, mem_b[{ifb.dm_addr[11:1], 1'b1}],
                                               mem_b[{ifb.dm_addr[11:1], 1'b0}]};
            default:      ifb.dm_dout = {mem_b[{ifb.dm_addr[11:2], 2'b11}], mem_b[{ifb.dm_addr[11:2], 2'b10}],
                                         mem_b[{ifb.dm_addr[11:2], 2'b01}], mem_b[{ifb.dm_addr[11:2], 2'b00}]};
        endcase
    end

    // Memory A preload and write port.
    always @(posedge clk) begin
        if (init_mem) begin
            mem_a[12'h004] <= 8'h44; mem_a[12'h005] <= 8'h33;
            mem_a[12'h006] <= 8'h22; mem_a[12'h007] <= 8'h11;
            mem_a[12'h010] <= 8'h00; mem_a[12'h011] <= 8'h80;
            mem_a[12'h012] <= 8'h01; mem_a[12'h013] <= 8'h80;
        end else if (ifa.dm_we) begin
            case (ifa.dm_mode)
                `MEM_op_byte: mem_a[ifa.dm_addr] <= ifa.dm_din[7:0];
                `MEM_op_half: begin
                    mem_a[{ifa.dm_addr[11:1], 1'b0}] <= ifa.dm_din[7:0];
                    mem_a[{ifa.dm_addr[11:1], 1'b1}] <= ifa.dm_din[15:8];
                end
                default: begin
                    mem_a[{ifa.dm_addr[11:2], 2'b00}] <= ifa.dm_din[7:0];
                    mem_a[{ifa.dm_addr[11:2], 2'b01}] <= ifa.dm_din[15:8];
                    mem_a[{ifa.dm_addr[11:2], 2'b10}] <= ifa.dm_din[23:16];
                    mem_a[{ifa.dm_addr[11:2], 2'b11}] <= ifa.dm_din[31:24];
                end
            endcase
        end
    end

    // Memory B preload and write port (word stores only are used on B).
    always @(posedge clk) begin
        if (init_mem) begin
            mem_b[12'h100] <= 8'h5A; mem_b[12'h101] <= 8'h5A;
            mem_b[12'h102] <= 8'hA5; mem_b[12'h103] <= 8'hA5;
            mem_b[12'h200] <= 8'h00; mem_b[12'h201] <= 8'h00;
            mem_b[12'h202] <= 8'h00; mem_b[12'h203] <= 8'h00;
        end else if (ifb.dm_we) begin
            mem_b[{ifb.dm_addr[11:2], 2'b00}] <= ifb.dm_din[7:0];
            mem_b[{ifb.dm_addr[11:2], 2'b01}] <= ifb.dm_din[15:8];
            mem_b[{ifb.dm_addr[11:2], 2'b10}] <= ifb.dm_din[23:16];
            mem_b[{ifb.dm_addr[11:2], 2'b11}] <= ifb.dm_din[31:24];
        end
    end

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        if (ifa.dm_we)      wr_cnt_a   <= wr_cnt_a + 1;
        if (ifb.dm_we)      wr_cnt_b   <= wr_cnt_b + 1;
        if (ifb.resp_valid) resp_cnt_b <= resp_cnt_b + 1;
    end

    // Bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic we, input logic [1:0] mode, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata);
        ifa.req_valid = 1'b1; ifa.req_we = we; ifa.req_mode = mode;
        ifa.req_signed = sgn; ifa.req_addr = addr; ifa.req_wdata = wdata;
    endtask

    // Aligned load on A (WAIT=1): ACCESS, RESP, IDLE on successive cycles.
    task automatic load_a(input string tag, input logic [1:0] mode, input logic sgn,
                          input logic [31:0] addr, input logic [11:0] exp_addr,
                          input logic [31:0] exp_data);
        drive_a(1'b0, mode, sgn, addr, 32'h0);
        @(negedge clk);
        ifa.req_valid = 1'b0;
        chk({tag, ".acc_stall"}, {31'h0, ifa.stall}, 32'd1);
        chk({tag, ".acc_ready"}, {31'h0, ifa.req_ready}, 32'd0);
        chk({tag, ".acc_addr"}, {20'h0, ifa.dm_addr}, {20'h0, exp_addr});
        chk({tag, ".acc_rv"}, {31'h0, ifa.resp_valid}, 32'd0);
        @(negedge clk);
        chk({tag, ".rv"}, {31'h0, ifa.resp_valid}, 32'd1);
        chk({tag, ".data"}, ifa.resp_rdata, exp_data);
        chk({tag, ".err"}, {31'h0, ifa.resp_err}, 32'd0);
        @(negedge clk);
        chk({tag, ".idle_rv"}, {31'h0, ifa.resp_valid}, 32'd0);
        chk({tag, ".idle_stall"}, {31'h0, ifa.stall}, 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        wr_cnt_a = 0; wr_cnt_b = 0; resp_cnt_b = 0;
        init_mem = 1'b1;
        rst = 1'b1;
        ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_mode = 2'b00;
        ifa.req_signed = 1'b0; ifa.req_addr = 32'h0; ifa.req_wdata = 32'h0;
        ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_mode = 2'b00;
        ifb.req_signed = 1'b0; ifb.req_addr = 32'h0; ifb.req_wdata = 32'h0;
        repeat (2) @(negedge clk);

        // Reset state.
        chk("rst.ready",  {31'h0, ifa.req_ready},  32'd1);
        chk("rst.rv",     {31'h0, ifa.resp_valid}, 32'd0);
        chk("rst.err",    {31'h0, ifa.resp_err},   32'd0);
        chk("rst.rdata",  ifa.resp_rdata,          32'h0);
        chk("rst.stall",  {31'h0, ifa.stall},      32'd0);
        chk("rst.we",     {31'h0, ifa.dm_we},      32'd0);
        chk("rst.addr",   {20'h0, ifa.dm_addr},    32'h0);
        chk("rst.din",    ifa.dm_din,              32'h0);
        chk("rst.mode",   {30'h0, ifa.dm_mode},    32'h0);
        chk("rst.b_stall",{31'h0, ifb.stall},      32'd0);
        rst = 1'b0;
        init_mem = 1'b0;
        @(negedge clk);

        // Byte/half loads with extension.
        load_a("lb",   M_BYTE, 1'b1, 32'h0000_0011, 12'h011, 32'hFFFF_FF80);
        load_a("lbu",  M_BYTE, 1'b0, 32'h0000_0011, 12'h011, 32'h0000_0080);
        load_a("lh",   M_HALF, 1'b1, 32'h0000_0012, 12'h012, 32'hFFFF_8001);
        load_a("lhu",  M_HALF, 1'b0, 32'h0000_0012, 12'h012, 32'h0000_8001);
        load_a("lb13", M_BYTE, 1'b1, 32'h0000_0013, 12'h013, 32'hFFFF_FF80);

        // Misaligned word and half: response in the next cycle, no memory write.
        drive_a(1'b0, M_WORD, 1'b0, 32'h0000_0013, 32'h0);
        @(negedge clk);
        ifa.req_valid = 1'b0;
        chk("lw_mis.rv",    {31'h0, ifa.resp_valid}, 32'd1);
        chk("lw_mis.err",   {31'h0, ifa.resp_err},   32'd1);
        chk("lw_mis.rdata", ifa.resp_rdata,          32'h0);
        @(negedge clk);
        chk("lw_mis.idle",  {31'h0, ifa.resp_valid}, 32'd0);
        drive_a(1'b1, M_HALF, 1'b0, 32'h0000_0013, 32'h0000_1234);
        @(negedge clk);
        ifa.req_valid = 1'b0;
        chk("sh_mis.rv",    {31'h0, ifa.resp_valid}, 32'd1);
        chk("sh_mis.err",   {31'h0, ifa.resp_err},   32'd1);
        chk("sh_mis.we",    {31'h0, ifa.dm_we},      32'd0);
        @(negedge clk);
        chk("mis.wr_cnt",   wr_cnt_a,                32'd0);

        // Aligned store word.
        drive_a(1'b1, M_WORD, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        @(negedge clk);
        ifa.req_valid = 1'b0;
        chk("sw.we",   {31'h0, ifa.dm_we},      32'd1);
        chk("sw.addr", {20'h0, ifa.dm_addr},    32'h010);
        chk("sw.din",  ifa.dm_din,              32'hDEAD_BEEF);
        chk("sw.rv0",  {31'h0, ifa.resp_valid}, 32'd0);
        @(negedge clk);
        chk("sw.we_off", {31'h0, ifa.dm_we},    32'd0);
        chk("sw.rv",   {31'h0, ifa.resp_valid}, 32'd1);
        chk("sw.err",  {31'h0, ifa.resp_err},   32'd0);
        chk("sw.rdata", ifa.resp_rdata,         32'h0);
        @(negedge clk);
        chk("sw.wr_cnt", wr_cnt_a,              32'd1);
        load_a("lw_back", M_WORD, 1'b0, 32'h0000_0010, 12'h010, 32'hDEAD_BEEF);

        // Address wrap above 4 KB.
        load_a("lw_wrap", M_WORD, 1'b0, 32'h0000_1004, 12'h004, 32'h1122_3344);

        // B: back-to-back word loads held on req_valid, WAIT=3.
        ifb.req_valid = 1'b1; ifb.req_we = 1'b0; ifb.req_mode = M_WORD;
        ifb.req_signed = 1'b0; ifb.req_addr = 32'h0000_0100; ifb.req_wdata = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("b2b.stall", {31'h0, ifb.stall},      32'd1);
            chk("b2b.ready", {31'h0, ifb.req_ready},  ((i % 4) == 0) ? 32'd1 : 32'd0);
            chk("b2b.rv",    {31'h0, ifb.resp_valid}, ((i % 4) == 0) ? 32'd1 : 32'd0);
            if ((i % 4) == 0) begin
                chk("b2b.data", ifb.resp_rdata, 32'hA5A5_5A5A);
            end
            if (i == 8) begin
                ifb.req_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b.idle",  {31'h0, ifb.stall}, 32'd0);
        chk("b2b.nresp", resp_cnt_b,         32'd2);

        // B: reset during the second ACCESS cycle of a store.
        ifb.req_valid = 1'b1; ifb.req_we = 1'b1; ifb.req_mode = M_WORD;
        ifb.req_addr = 32'h0000_0200; ifb.req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        ifb.req_valid = 1'b0;
        chk("rstacc.stall", {31'h0, ifb.stall}, 32'd1);
        chk("rstacc.we1",   {31'h0, ifb.dm_we}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstacc.we",    {31'h0, ifb.dm_we},      32'd0);
        chk("rstacc.st",    {31'h0, ifb.stall},      32'd0);
        chk("rstacc.ready", {31'h0, ifb.req_ready},  32'd1);
        chk("rstacc.rv",    {31'h0, ifb.resp_valid}, 32'd0);
        chk("rstacc.addr",  {20'h0, ifb.dm_addr},    32'h0);
        chk("rstacc.din",   ifb.dm_din,              32'h0);
        chk("rstacc.mode",  {30'h0, ifb.dm_mode},    32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstacc.wr_cnt", wr_cnt_b,   32'd0);
        chk("rstacc.nresp",  resp_cnt_b, 32'd2);
        chk("rstacc.mem", {mem_b[12'h203], mem_b[12'h202], mem_b[12'h201], mem_b[12'h200]}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
